stopwatch_sequencer: RTL and testbench

- Front-end controller for the stopwatch run/halt process FSM.
- Converts two asynchronous, pre-debounced push-button levels into single-cycle command pulses: run trigger, halt trigger and soft reset.
- Owns the lap-freeze state and generates the counting time-base tick that advances the time counter.
- Sits between the board buttons and the process FSM / time counter / display path.

---
 rtl/stopwatch_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_stopwatch_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/stopwatch_sequencer.sv
// rtl/stopwatch_sequencer.sv - button front-end, run/halt/lap sequencer and time-base tick generator

// Multi-flop level synchronizer; the chain presets to 1 so a button that is
// already held while reset is asserted looks like "still pressed" afterwards.
module stopwatch_sequencer_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clock,
  input  logic i_async_rst_n,
  input  logic i_level,
  output logic o_level
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  // Shift the raw level one stage deeper each clock.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], i_level};
  end

  // Chain register, preset high on reset.
  always_ff @(posedge i_clock or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      chain_q <= '1;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign o_level = chain_q[STAGES-1];

endmodule

module stopwatch_sequencer #(
  parameter int CLK_DIV     = 100000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clock,
  input  logic       i_async_rst_n,
  input  logic       i_btn_start_stop,
  input  logic       i_btn_lap_reset,
  output logic       o_trigger_run,
  output logic       o_trigger_halt,
  output logic       o_soft_reset,
  output logic       o_tick,
  output logic       o_lap_freeze,
  output logic [1:0] o_state
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_LAP    = 2'b11
  } state_t;

  logic ss_sync;
  logic lr_sync;
  logic ss_prev_q, ss_prev_d;
  logic lr_prev_q, lr_prev_d;
  logic ss_press;
  logic lr_press;

  state_t        state_q, state_d;
  logic          run_q, run_d;
  logic          halt_q, halt_d;
  logic          soft_q, soft_d;
  logic          tick_q, tick_d;
  logic          freeze_q, freeze_d;
  logic [PW-1:0] presc_q, presc_d;

  stopwatch_sequencer_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
    .i_clock       (i_clock),
    .i_async_rst_n (i_async_rst_n),
    .i_level       (i_btn_start_stop),
    .o_level       (ss_sync)
  );

  stopwatch_sequencer_sync #(.STAGES(SYNC_STAGES)) u_sync_lr (
    .i_clock       (i_clock),
    .i_async_rst_n (i_async_rst_n),
    .i_level       (i_btn_lap_reset),
    .o_level       (lr_sync)
  );

  // Rising-edge detect on the synchronized levels: one press per hold.
  always_comb begin
    ss_prev_d = ss_sync;
    lr_prev_d = lr_sync;
    ss_press  = ss_sync & ~ss_prev_q;
    lr_press  = lr_sync & ~lr_prev_q;
  end

  // Next state and command pulses; start_stop wins and a coincident
  // lap_reset press is simply dropped.
  always_comb begin
    state_d = state_q;
    run_d   = 1'b0;
    halt_d  = 1'b0;
    soft_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_press) begin
          state_d = ST_RUN;
          run_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (ss_press) begin
          state_d = ST_PAUSED;
          halt_d  = 1'b1;
        end else if (lr_press) begin
          state_d = ST_LAP;
        end
      end
      ST_LAP: begin
        if (ss_press) begin
          state_d = ST_PAUSED;
          halt_d  = 1'b1;
        end else if (lr_press) begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSED: begin
        if (ss_press) begin
          state_d = ST_RUN;
          run_d   = 1'b1;
        end else if (lr_press) begin
          state_d = ST_IDLE;
          soft_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    freeze_d = (state_d == ST_LAP);
  end

  // Prescaler: counts on the current (pre-edge) state, holds in PAUSED so
  // sub-tick phase survives a pause, and is zeroed in or on entry to IDLE.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if ((state_q == ST_RUN) || (state_q == ST_LAP)) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    if ((state_q == ST_IDLE) || (state_d == ST_IDLE)) begin
      presc_d = '0;
    end
  end

  // Edge-detect history; preset high to match the synchronizer preset.
  always_ff @(posedge i_clock or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      ss_prev_q <= 1'b1;
      lr_prev_q <= 1'b1;
    end else begin
      ss_prev_q <= ss_prev_d;
      lr_prev_q <= lr_prev_d;
    end
  end

  // State, registered outputs and prescaler.
  always_ff @(posedge i_clock or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      state_q  <= ST_IDLE;
      run_q    <= 1'b0;
      halt_q   <= 1'b0;
      soft_q   <= 1'b0;
      tick_q   <= 1'b0;
      freeze_q <= 1'b0;
      presc_q  <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      halt_q   <= halt_d;
      soft_q   <= soft_d;
      tick_q   <= tick_d;
      freeze_q <= freeze_d;
      presc_q  <= presc_d;
    end
  end

  assign o_trigger_run  = run_q;
  assign o_trigger_halt = halt_q;
  assign o_soft_reset   = soft_q;
  assign o_tick         = tick_q;
  assign o_lap_freeze   = freeze_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// tb/tb_stopwatch_sequencer.sv - directed bench for stopwatch_sequencer (CLK_DIV=4)

module tb_stopwatch_sequencer;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ss    = 1'b0;
  logic       lr    = 1'b0;
  logic       o_trigger_run;
  logic       o_trigger_halt;
  logic       o_soft_reset;
  logic       o_tick;
  logic       o_lap_freeze;
  logic [1:0] o_state;
  logic [6:0] obs;

  int checks = 0;
  int errors = 0;

  stopwatch_sequencer #(.CLK_DIV(4), .SYNC_STAGES(2)) dut (
    .i_clock          (clk),
    .i_async_rst_n    (rst_n),
    .i_btn_start_stop (ss),
    .i_btn_lap_reset  (lr),
    .o_trigger_run    (o_trigger_run),
    .o_trigger_halt   (o_trigger_halt),
    .o_soft_reset     (o_soft_reset),
    .o_tick           (o_tick),
    .o_lap_freeze     (o_lap_freeze),
    .o_state          (o_state)
  );

  always #5 clk = ~clk;

  // {run, halt, soft, tick, freeze, state[1:0]}
  assign obs = {o_trigger_run, o_trigger_halt, o_soft_reset, o_tick, o_lap_freeze, o_state};

  task automatic check(input string tag, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic r, input logic h, input logic s,
                      input logic t, input logic f, input logic [1:0] st);
    cyc();
    check(tag, {r, h, s, t, f, st});
  endtask

  // n quiet cycles: no pulse, no tick, freeze follows LAP.
  task automatic hold(input string tag, input int n, input logic [1:0] st);
    for (int i = 0; i < n; i++) begin
      step(tag, 1'b0, 1'b0, 1'b0, 1'b0, (st == 2'b11), st);
    end
  endtask

  initial begin
    // reset state
    cyc();
    cyc();
    check("reset", 7'b0000000);
    rst_n = 1'b1;
    hold("idle_quiet", 20, 2'b00);

    // start from IDLE: pulse on 3rd edge, then ticks every 4 cycles
    ss = 1'b1;
    hold("ss_sync", 2, 2'b00);
    step("run_pulse", 1, 0, 0, 0, 0, 2'b01);
    hold("run_p", 3, 2'b01);
    ss = 1'b0;
    step("tick_a", 0, 0, 0, 1, 0, 2'b01);
    hold("run_q", 3, 2'b01);
    step("tick_b", 0, 0, 0, 1, 0, 2'b01);

    // lap in and out, ticks uninterrupted
    lr = 1'b1;
    hold("lr_sync", 2, 2'b01);
    step("lap_enter", 0, 0, 0, 0, 1, 2'b11);
    step("lap_tick", 0, 0, 0, 1, 1, 2'b11);
    lr = 1'b0;
    hold("lap_hold", 2, 2'b11);
    lr = 1'b1;
    hold("lap_sync", 1, 2'b11);
    step("lap_tick2", 0, 0, 0, 1, 1, 2'b11);
    step("lap_exit", 0, 0, 0, 0, 0, 2'b01);
    lr = 1'b0;
    hold("run_r", 2, 2'b01);

    // halt with prescaler at 2, no ticks while paused, phase kept on resume
    ss = 1'b1;
    step("tick_c", 0, 0, 0, 1, 0, 2'b01);
    hold("run_s", 1, 2'b01);
    step("halt_pulse", 0, 1, 0, 0, 0, 2'b10);
    ss = 1'b0;
    hold("paused_quiet", 8, 2'b10);
    ss = 1'b1;
    hold("resume_sync", 2, 2'b10);
    step("resume_run", 1, 0, 0, 0, 0, 2'b01);
    ss = 1'b0;
    hold("resume_p", 1, 2'b01);
    step("phase_tick", 0, 0, 0, 1, 0, 2'b01);
    hold("run_t", 1, 2'b01);

    // halt edge coinciding with a wrap still emits the tick
    ss = 1'b1;
    hold("run_u", 2, 2'b01);
    step("halt_wrap", 0, 1, 0, 1, 0, 2'b10);
    ss = 1'b0;
    hold("paused_b", 3, 2'b10);

    // simultaneous presses in PAUSED: start_stop only, lap_reset dropped
    ss = 1'b1;
    lr = 1'b1;
    hold("both_sync", 2, 2'b10);
    step("both_run", 1, 0, 0, 0, 0, 2'b01);
    ss = 1'b0;
    lr = 1'b0;
    hold("both_after", 3, 2'b01);
    step("both_tick", 0, 0, 0, 1, 0, 2'b01);

    // PAUSED + lap_reset -> soft reset, prescaler cleared
    ss = 1'b1;
    hold("run_v", 2, 2'b01);
    step("halt3", 0, 1, 0, 0, 0, 2'b10);
    ss = 1'b0;
    hold("paused_c", 1, 2'b10);
    lr = 1'b1;
    hold("soft_sync", 2, 2'b10);
    step("soft_reset", 0, 0, 1, 0, 0, 2'b00);
    lr = 1'b0;
    hold("idle_b", 1, 2'b00);
    ss = 1'b1;
    hold("idle_sync", 2, 2'b00);
    step("run_from_idle", 1, 0, 0, 0, 0, 2'b01);
    ss = 1'b0;
    hold("run_w", 3, 2'b01);
    step("presc_cleared_tick", 0, 0, 0, 1, 0, 2'b01);

    // asynchronous reset mid-RUN, button held across release
    #2;
    rst_n = 1'b0;
    ss    = 1'b1;
    #1;
    check("async_reset", 7'b0000000);
    cyc();
    cyc();
    check("in_reset", 7'b0000000);
    rst_n = 1'b1;
    hold("held_thru_reset", 6, 2'b00);
    ss = 1'b0;
    hold("release", 3, 2'b00);
    ss = 1'b1;
    hold("repress_sync", 2, 2'b00);
    step("repress_run", 1, 0, 0, 0, 0, 2'b01);
    step("repress_width", 0, 0, 0, 0, 0, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
